inst_encoder: RTL and testbench

Pipelined RV32I/Zicsr instruction encoder, the inverse of `inst_decoder`. It accepts an operation code plus register and immediate fields over a valid/ready handshake. It emits the 32-bit machine word, or an error flag, after one register stage, with a 2-entry skid buffer for full throughput under backpressure. It feeds instruction-memory preload logic and self-checking encode→decode loopback benches.

---
 rtl/inst_pkg.sv | 100 ++++++++++
 rtl/inst_encode_comb.sv | 139 +++++++++++++
 rtl/inst_encoder.sv | 121 ++++++++++++
 tb/tb_inst_encoder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_pkg.sv
// Shared RV32I/Zicsr encoding constants for the instruction encoder and decoder.
// Op codes, base opcodes, funct3/funct7 values and instruction format classes.
package inst_pkg;

  localparam int OP_W = 6;

  localparam logic [5:0] OP_LUI    = 6'd0;
  localparam logic [5:0] OP_AUIPC  = 6'd1;
  localparam logic [5:0] OP_JAL    = 6'd2;
  localparam logic [5:0] OP_JALR   = 6'd3;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_BNE    = 6'd5;
  localparam logic [5:0] OP_BLT    = 6'd6;
  localparam logic [5:0] OP_BGE    = 6'd7;
  localparam logic [5:0] OP_BLTU   = 6'd8;
  localparam logic [5:0] OP_BGEU   = 6'd9;
  localparam logic [5:0] OP_LB     = 6'd10;
  localparam logic [5:0] OP_LH     = 6'd11;
  localparam logic [5:0] OP_LW     = 6'd12;
  localparam logic [5:0] OP_LBU    = 6'd13;
  localparam logic [5:0] OP_LHU    = 6'd14;
  localparam logic [5:0] OP_SB     = 6'd15;
  localparam logic [5:0] OP_SH     = 6'd16;
  localparam logic [5:0] OP_SW     = 6'd17;
  localparam logic [5:0] OP_ADDI   = 6'd18;
  localparam logic [5:0] OP_SLTI   = 6'd19;
  localparam logic [5:0] OP_SLTIU  = 6'd20;
  localparam logic [5:0] OP_XORI   = 6'd21;
  localparam logic [5:0] OP_ORI    = 6'd22;
  localparam logic [5:0] OP_ANDI   = 6'd23;
  localparam logic [5:0] OP_SLLI   = 6'd24;
  localparam logic [5:0] OP_SRLI   = 6'd25;
  localparam logic [5:0] OP_SRAI   = 6'd26;
  localparam logic [5:0] OP_ADD    = 6'd27;
  localparam logic [5:0] OP_SUB    = 6'd28;
  localparam logic [5:0] OP_SLL    = 6'd29;
  localparam logic [5:0] OP_SLT    = 6'd30;
  localparam logic [5:0] OP_SLTU   = 6'd31;
  localparam logic [5:0] OP_XOR    = 6'd32;
  localparam logic [5:0] OP_SRL    = 6'd33;
  localparam logic [5:0] OP_SRA    = 6'd34;
  localparam logic [5:0] OP_OR     = 6'd35;
  localparam logic [5:0] OP_AND    = 6'd36;
  localparam logic [5:0] OP_FENCE  = 6'd37;
  localparam logic [5:0] OP_FENCE_I = 6'd38;
  localparam logic [5:0] OP_ECALL  = 6'd39;
  localparam logic [5:0] OP_EBREAK = 6'd40;
  localparam logic [5:0] OP_CSRRW  = 6'd41;
  localparam logic [5:0] OP_CSRRS  = 6'd42;
  localparam logic [5:0] OP_CSRRC  = 6'd43;
  localparam logic [5:0] OP_CSRRWI = 6'd44;
  localparam logic [5:0] OP_CSRRSI = 6'd45;
  localparam logic [5:0] OP_CSRRCI = 6'd46;
  localparam logic [5:0] OP_COUNT  = 6'd47;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE  = 3'd1, F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_LB   = 3'd0, F3_LH   = 3'd1, F3_LW   = 3'd2;
  localparam logic [2:0] F3_LBU  = 3'd4, F3_LHU  = 3'd5;
  localparam logic [2:0] F3_SB   = 3'd0, F3_SH   = 3'd1, F3_SW   = 3'd2;
  localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL  = 3'd1, F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3, F3_XOR  = 3'd4, F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6, F3_AND  = 3'd7, F3_JALR = 3'd0;
  localparam logic [2:0] F3_FENCE = 3'd0, F3_FENCE_I = 3'd1, F3_PRIV = 3'd0;
  localparam logic [2:0] F3_CSRRW  = 3'd1, F3_CSRRS  = 3'd2, F3_CSRRC  = 3'd3;
  localparam logic [2:0] F3_CSRRWI = 3'd5, F3_CSRRSI = 3'd6, F3_CSRRCI = 3'd7;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS} fmt_e;

  typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_TWO} skid_e;

  // FENCE, FENCE_I, ECALL/EBREAK and CSR ops all land in FMT_SYS.
  function automatic fmt_e op_format(input logic [5:0] op);
    if (op <= OP_AUIPC)     return FMT_U;
    else if (op == OP_JAL)  return FMT_J;
    else if (op == OP_JALR) return FMT_I;
    else if (op <= OP_BGEU) return FMT_B;
    else if (op <= OP_LHU)  return FMT_I;
    else if (op <= OP_SW)   return FMT_S;
    else if (op <= OP_SRAI) return FMT_I;
    else if (op <= OP_AND)  return FMT_R;
    else                    return FMT_SYS;
  endfunction

endpackage

// File: rtl/inst_encode_comb.sv
// Purely combinational {op, fields} -> {inst, err} encoder for RV32I/Zicsr.
// An unencodable request yields err=1 with an all-zero instruction word.
module inst_encode_comb
  import inst_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_inst,
  output logic        o_err
);

  logic [6:0]  w_opc;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  fmt_e        w_fmt;
  logic        w_shift;
  logic        w_i_ok;
  logic        w_b_ok;
  logic        w_j_ok;
  logic [31:0] w_inst;
  logic        w_err;

  // Range checks reduce to "all high bits equal the sign bit".
  assign w_i_ok  = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_b_ok  = ((&i_imm[31:12]) | ~(|i_imm[31:12])) & ~i_imm[0];
  assign w_j_ok  = ((&i_imm[31:20]) | ~(|i_imm[31:20])) & ~i_imm[0];
  assign w_shift = (i_op == OP_SLLI) | (i_op == OP_SRLI) | (i_op == OP_SRAI);
  assign w_fmt   = op_format(i_op);

  always_comb begin
    w_opc = OPC_OP;
    w_f3  = 3'd0;
    w_f7  = F7_BASE;
    case (i_op)
      OP_LUI:     w_opc = OPC_LUI;
      OP_AUIPC:   w_opc = OPC_AUIPC;
      OP_JAL:     w_opc = OPC_JAL;
      OP_JALR:    begin w_opc = OPC_JALR;   w_f3 = F3_JALR; end
      OP_BEQ:     begin w_opc = OPC_BRANCH; w_f3 = F3_BEQ;  end
      OP_BNE:     begin w_opc = OPC_BRANCH; w_f3 = F3_BNE;  end
      OP_BLT:     begin w_opc = OPC_BRANCH; w_f3 = F3_BLT;  end
      OP_BGE:     begin w_opc = OPC_BRANCH; w_f3 = F3_BGE;  end
      OP_BLTU:    begin w_opc = OPC_BRANCH; w_f3 = F3_BLTU; end
      OP_BGEU:    begin w_opc = OPC_BRANCH; w_f3 = F3_BGEU; end
      OP_LB:      begin w_opc = OPC_LOAD;   w_f3 = F3_LB;   end
      OP_LH:      begin w_opc = OPC_LOAD;   w_f3 = F3_LH;   end
      OP_LW:      begin w_opc = OPC_LOAD;   w_f3 = F3_LW;   end
      OP_LBU:     begin w_opc = OPC_LOAD;   w_f3 = F3_LBU;  end
      OP_LHU:     begin w_opc = OPC_LOAD;   w_f3 = F3_LHU;  end
      OP_SB:      begin w_opc = OPC_STORE;  w_f3 = F3_SB;   end
      OP_SH:      begin w_opc = OPC_STORE;  w_f3 = F3_SH;   end
      OP_SW:      begin w_opc = OPC_STORE;  w_f3 = F3_SW;   end
      OP_ADDI:    begin w_opc = OPC_OP_IMM; w_f3 = F3_ADD;  end
      OP_SLTI:    begin w_opc = OPC_OP_IMM; w_f3 = F3_SLT;  end
      OP_SLTIU:   begin w_opc = OPC_OP_IMM; w_f3 = F3_SLTU; end
      OP_XORI:    begin w_opc = OPC_OP_IMM; w_f3 = F3_XOR;  end
      OP_ORI:     begin w_opc = OPC_OP_IMM; w_f3 = F3_OR;   end
      OP_ANDI:    begin w_opc = OPC_OP_IMM; w_f3 = F3_AND;  end
      OP_SLLI:    begin w_opc = OPC_OP_IMM; w_f3 = F3_SLL;  end
      OP_SRLI:    begin w_opc = OPC_OP_IMM; w_f3 = F3_SR;   end
      OP_SRAI:    begin w_opc = OPC_OP_IMM; w_f3 = F3_SR;   w_f7 = F7_ALT; end
      OP_ADD:     w_f3 = F3_ADD;
      OP_SUB:     begin w_f3 = F3_ADD; w_f7 = F7_ALT; end
      OP_SLL:     w_f3 = F3_SLL;
      OP_SLT:     w_f3 = F3_SLT;
      OP_SLTU:    w_f3 = F3_SLTU;
      OP_XOR:     w_f3 = F3_XOR;
      OP_SRL:     w_f3 = F3_SR;
      OP_SRA:     begin w_f3 = F3_SR;  w_f7 = F7_ALT; end
      OP_OR:      w_f3 = F3_OR;
      OP_AND:     w_f3 = F3_AND;
      OP_FENCE:   begin w_opc = OPC_MISC_MEM; w_f3 = F3_FENCE;   end
      OP_FENCE_I: begin w_opc = OPC_MISC_MEM; w_f3 = F3_FENCE_I; end
      OP_ECALL:   begin w_opc = OPC_SYSTEM;   w_f3 = F3_PRIV;    end
      OP_EBREAK:  begin w_opc = OPC_SYSTEM;   w_f3 = F3_PRIV;    end
      OP_CSRRW:   begin w_opc = OPC_SYSTEM;   w_f3 = F3_CSRRW;   end
      OP_CSRRS:   begin w_opc = OPC_SYSTEM;   w_f3 = F3_CSRRS;   end
      OP_CSRRC:   begin w_opc = OPC_SYSTEM;   w_f3 = F3_CSRRC;   end
      OP_CSRRWI:  begin w_opc = OPC_SYSTEM;   w_f3 = F3_CSRRWI;  end
      OP_CSRRSI:  begin w_opc = OPC_SYSTEM;   w_f3 = F3_CSRRSI;  end
      OP_CSRRCI:  begin w_opc = OPC_SYSTEM;   w_f3 = F3_CSRRCI;  end
      default:    w_opc = OPC_OP;
    endcase
  end

  always_comb begin
    w_inst = 32'd0;
    w_err  = 1'b0;
    case (w_fmt)
      FMT_R: w_inst = {w_f7, i_rs2, i_rs1, w_f3, i_rd, w_opc};
      FMT_I: begin
        if (w_shift) begin
          w_err  = |i_imm[31:5];
          w_inst = {w_f7, i_imm[4:0], i_rs1, w_f3, i_rd, w_opc};
        end else begin
          w_err  = ~w_i_ok;
          w_inst = {i_imm[11:0], i_rs1, w_f3, i_rd, w_opc};
        end
      end
      FMT_S: begin
        w_err  = ~w_i_ok;
        w_inst = {i_imm[11:5], i_rs2, i_rs1, w_f3, i_imm[4:0], w_opc};
      end
      FMT_B: begin
        w_err  = ~w_b_ok;
        w_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3, i_imm[4:1], i_imm[11], w_opc};
      end
      FMT_U: begin
        w_err  = |i_imm[11:0];
        w_inst = {i_imm[31:12], i_rd, w_opc};
      end
      FMT_J: begin
        w_err  = ~w_j_ok;
        w_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, w_opc};
      end
      FMT_SYS: begin
        // ECALL/EBREAK differ only in imm[0]; FENCE_I carries no registers.
        if ((i_op == OP_ECALL) || (i_op == OP_EBREAK)) begin
          w_inst = {11'd0, (i_op == OP_EBREAK), 13'd0, w_opc};
        end else if (i_op == OP_FENCE_I) begin
          w_err  = |i_imm[31:12];
          w_inst = {i_imm[11:0], 5'd0, w_f3, 5'd0, w_opc};
        end else begin
          w_err  = |i_imm[31:12];
          w_inst = {i_imm[11:0], i_rs1, w_f3, i_rd, w_opc};
        end
      end
      default: w_inst = 32'd0;
    endcase
    if (i_op >= OP_COUNT) w_err = 1'b1;
  end

  assign o_err  = w_err;
  assign o_inst = w_err ? 32'd0 : w_inst;

endmodule

// File: rtl/inst_encoder.sv
// Registered RV32I/Zicsr encoder with a two-entry skid buffer and saturating
// result counters; encoding itself lives in inst_encode_comb.
//
// state      | meaning
// SKID_EMPTY | nothing buffered, o_valid=0
// SKID_ONE   | output register holds a result
// SKID_TWO   | output register and skid entry full, o_ready=0
module inst_encoder
  import inst_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [5:0]       i_op,
  input  logic [4:0]       i_rd,
  input  logic [4:0]       i_rs1,
  input  logic [4:0]       i_rs2,
  input  logic [31:0]      i_imm,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_inst,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cnt_ok,
  output logic [CNT_W-1:0] o_cnt_err
);

  logic [31:0]      w_inst;
  logic             w_err;
  logic             w_accept;
  logic             w_deliver;

  skid_e            r_state;
  logic             r_ready;
  logic [31:0]      r_out_inst;
  logic             r_out_err;
  logic [31:0]      r_skid_inst;
  logic             r_skid_err;
  logic [CNT_W-1:0] r_cnt_ok;
  logic [CNT_W-1:0] r_cnt_err;

  inst_encode_comb u_encode (
    .i_op   (i_op),
    .i_rd   (i_rd),
    .i_rs1  (i_rs1),
    .i_rs2  (i_rs2),
    .i_imm  (i_imm),
    .o_inst (w_inst),
    .o_err  (w_err)
  );

  assign w_accept  = i_valid & r_ready;
  assign w_deliver = (r_state != SKID_EMPTY) & i_ready;

  // r_ready is only cleared when entering SKID_TWO, so no accept happens there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= SKID_EMPTY;
      r_ready     <= 1'b1;
      r_out_inst  <= 32'd0;
      r_out_err   <= 1'b0;
      r_skid_inst <= 32'd0;
      r_skid_err  <= 1'b0;
      r_cnt_ok    <= '0;
      r_cnt_err   <= '0;
    end else begin
      case (r_state)
        SKID_EMPTY: begin
          if (w_accept) begin
            r_out_inst <= w_inst;
            r_out_err  <= w_err;
            r_state    <= SKID_ONE;
          end
        end
        SKID_ONE: begin
          if (w_accept && w_deliver) begin
            r_out_inst <= w_inst;
            r_out_err  <= w_err;
          end else if (w_accept) begin
            r_skid_inst <= w_inst;
            r_skid_err  <= w_err;
            r_ready     <= 1'b0;
            r_state     <= SKID_TWO;
          end else if (w_deliver) begin
            r_state <= SKID_EMPTY;
          end
        end
        SKID_TWO: begin
          if (w_deliver) begin
            r_out_inst <= r_skid_inst;
            r_out_err  <= r_skid_err;
            r_ready    <= 1'b1;
            r_state    <= SKID_ONE;
          end
        end
        default: begin
          r_state <= SKID_EMPTY;
          r_ready <= 1'b1;
        end
      endcase

      if (w_deliver) begin
        if (r_out_err) begin
          if (r_cnt_err != {CNT_W{1'b1}}) r_cnt_err <= r_cnt_err + CNT_W'(1);
        end else begin
          if (r_cnt_ok != {CNT_W{1'b1}}) r_cnt_ok <= r_cnt_ok + CNT_W'(1);
        end
      end
    end
  end

  assign o_ready   = r_ready;
  assign o_valid   = (r_state != SKID_EMPTY);
  assign o_inst    = r_out_inst;
  assign o_err     = r_out_err;
  assign o_cnt_ok  = r_cnt_ok;
  assign o_cnt_err = r_cnt_err;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed vector table, backpressure and reset
// sequences, and randomized traffic against a field-arithmetic reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        i_rst_n, i_valid, i_ready;
  logic [5:0]  i_op;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [31:0] i_imm;
  logic        o_ready, o_valid, o_err;
  logic [31:0] o_inst;
  logic [15:0] o_cnt_ok, o_cnt_err;
  logic        s_ready4, s_valid4, s_err4;
  logic [31:0] s_inst4;
  logic [3:0]  s_cnt_ok4, s_cnt_err4;

  always #5 clk = ~clk;

  inst_encoder #(.CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst), .o_err(o_err),
    .o_cnt_ok(o_cnt_ok), .o_cnt_err(o_cnt_err));

  inst_encoder #(.CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(s_ready4),
    .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
    .o_valid(s_valid4), .i_ready(i_ready), .o_inst(s_inst4), .o_err(s_err4),
    .o_cnt_ok(s_cnt_ok4), .o_cnt_err(s_cnt_err4));

  typedef struct {logic [5:0] op; logic [4:0] rd, rs1, rs2; logic [31:0] imm;} req_t;
  typedef struct {logic [31:0] inst; logic err;} res_t;
  typedef struct {req_t r; res_t x;} vec_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];
  int   exp_ok = 0;
  int   exp_err = 0;

  int br_f3[6]  = '{0, 1, 4, 5, 6, 7};
  int ld_f3[5]  = '{0, 1, 2, 4, 5};
  int ia_f3[6]  = '{0, 2, 3, 4, 6, 7};
  int sh_f3[3]  = '{1, 5, 5};
  int sh_alt[3] = '{0, 0, 1};
  int r_f3[10]  = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
  int r_alt[10] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
  int csr_f3[6] = '{1, 2, 3, 5, 6, 7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint bits(input longint v, input int hi, input int lo);
    return (v >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
  endfunction

  function automatic longint enc_i(input longint imm, input longint rs1, input longint f3,
                                   input longint rd, input longint opc);
    return (bits(imm, 11, 0) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | opc;
  endfunction

  // Reference: encoding rules written as signed-range tests and field arithmetic.
  function automatic res_t model(input req_t r);
    res_t   res;
    longint s   = longint'($signed(r.imm));
    longint rd  = longint'(r.rd);
    longint rs1 = longint'(r.rs1);
    longint rs2 = longint'(r.rs2);
    int     o   = int'(r.op);
    bit     e   = 1'b0;
    longint w   = 0;
    if (o >= 47) e = 1'b1;
    else if (o <= 1) begin
      e = (s % 4096) != 0;
      w = (s & 'hFFFFF000) | (rd << 7) | (o == 0 ? 'h37 : 'h17);
    end else if (o == 2) begin
      e = (s < -(1 << 20)) || (s > (1 << 20) - 2) || (s % 2 != 0);
      w = (bits(s, 20, 20) << 31) | (bits(s, 10, 1) << 21) | (bits(s, 11, 11) << 20) |
          (bits(s, 19, 12) << 12) | (rd << 7) | 'h6F;
    end else if (o == 3 || (o >= 10 && o <= 14) || (o >= 18 && o <= 23)) begin
      e = (s < -2048) || (s > 2047);
      if (o == 3)       w = enc_i(s, rs1, 0, rd, 'h67);
      else if (o <= 14) w = enc_i(s, rs1, ld_f3[o-10], rd, 'h03);
      else              w = enc_i(s, rs1, ia_f3[o-18], rd, 'h13);
    end else if (o <= 9) begin
      e = (s < -4096) || (s > 4094) || (s % 2 != 0);
      w = (bits(s, 12, 12) << 31) | (bits(s, 10, 5) << 25) | (rs2 << 20) | (rs1 << 15) |
          (longint'(br_f3[o-4]) << 12) | (bits(s, 4, 1) << 8) | (bits(s, 11, 11) << 7) | 'h63;
    end else if (o <= 17) begin
      e = (s < -2048) || (s > 2047);
      w = (bits(s, 11, 5) << 25) | (rs2 << 20) | (rs1 << 15) | (longint'(o - 15) << 12) |
          (bits(s, 4, 0) << 7) | 'h23;
    end else if (o <= 26) begin
      e = (s < 0) || (s > 31);
      w = (longint'(sh_alt[o-24]) << 30) | enc_i(s, rs1, sh_f3[o-24], rd, 'h13);
    end else if (o <= 36) begin
      w = (longint'(r_alt[o-27]) << 30) | (rs2 << 20) | (rs1 << 15) |
          (longint'(r_f3[o-27]) << 12) | (rd << 7) | 'h33;
    end else if (o == 37) begin
      e = (s < 0) || (s > 4095);
      w = enc_i(s, rs1, 0, rd, 'h0F);
    end else if (o == 38) begin
      e = (s < 0) || (s > 4095);
      w = enc_i(s, 0, 1, 0, 'h0F);
    end else if (o == 39) w = 'h73;
    else if (o == 40) w = 'h00100073;
    else begin
      e = (s < 0) || (s > 4095);
      w = enc_i(s, rs1, csr_f3[o-41], rd, 'h73);
    end
    res.err  = e;
    res.inst = e ? 32'd0 : w[31:0];
    return res;
  endfunction

  // One clock: drive at negedge, check against the queue model, predict the edge.
  task automatic cycle(input bit v, input bit rdy, input req_t r, input bit use_tab,
                       input res_t tab, output bit acc);
    res_t e;
    @(negedge clk);
    i_valid = v; i_ready = rdy;
    i_op = r.op; i_rd = r.rd; i_rs1 = r.rs1; i_rs2 = r.rs2; i_imm = r.imm;
    #1;
    chk("o_valid", 32'(o_valid), 32'(exp_q.size() != 0));
    chk("o_ready", 32'(o_ready), 32'(exp_q.size() < 2));
    acc = v && (exp_q.size() < 2);
    if (rdy && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("o_inst", o_inst, e.inst);
      chk("o_err", 32'(o_err), 32'(e.err));
      if (e.err) exp_err++;
      else exp_ok++;
    end
    if (acc) exp_q.push_back(use_tab ? tab : model(r));
  endtask

  task automatic idle(input bit rdy);
    req_t r;
    res_t x;
    bit   a;
    r = '{op: 6'd0, rd: 5'd0, rs1: 5'd0, rs2: 5'd0, imm: 32'd0};
    x = '{inst: 32'd0, err: 1'b0};
    cycle(1'b0, rdy, r, 1'b0, x, a);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      idle(1'b1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end
    @(negedge clk);
    #1;
    chk("cnt_ok", 32'(o_cnt_ok), 32'(exp_ok));
    chk("cnt_err", 32'(o_cnt_err), 32'(exp_err));
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0;
    repeat (2) @(negedge clk);
    i_rst_n = 1'b1;
    exp_q.delete();
    exp_ok = 0; exp_err = 0;
  endtask

  function automatic req_t mk(input int op, input int rd, input int rs1, input int rs2,
                              input logic [31:0] imm);
    req_t r;
    r.op = 6'(op); r.rd = 5'(rd); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.imm = imm;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   t;
    r = mk($urandom_range(0, 46), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 31), 32'd0);
    if (r.op <= 1) r.imm = {$urandom_range(0, 32'hFFFFF), 12'd0} & 32'hFFFFF000;
    else if (r.op == 2) begin
      t = $urandom_range(0, (1 << 20) - 1) * 2 - (1 << 20); r.imm = 32'(t);
    end else if (r.op >= 4 && r.op <= 9) begin
      t = $urandom_range(0, 4095) * 2 - 4096; r.imm = 32'(t);
    end else if (r.op >= 24 && r.op <= 26) r.imm = 32'($urandom_range(0, 31));
    else if (r.op >= 37) r.imm = 32'($urandom_range(0, 4095));
    else begin
      t = $urandom_range(0, 4095) - 2048; r.imm = 32'(t);
    end
    if (r.op == 39 || r.op == 40 || $urandom_range(0, 9) == 0) r.imm = $urandom;
    if ($urandom_range(0, 39) == 0) r.op = 6'($urandom_range(47, 63));
    return r;
  endfunction

  vec_t tab[19];
  req_t rq[3];
  res_t none;
  bit   acc;

  initial begin
    none = '{inst: 32'd0, err: 1'b0};
    tab[0]  = '{mk(18, 1, 0, 0, 32'd5),          '{32'h00500093, 1'b0}};
    tab[1]  = '{mk(0, 5, 0, 0, 32'h12345000),    '{32'h123452B7, 1'b0}};
    tab[2]  = '{mk(28, 3, 1, 2, 32'd0),          '{32'h402081B3, 1'b0}};
    tab[3]  = '{mk(4, 7, 1, 2, 32'd8),           '{32'h00208463, 1'b0}};
    tab[4]  = '{mk(18, 1, 0, 0, 32'd2048),       '{32'h0, 1'b1}};
    tab[5]  = '{mk(2, 1, 0, 0, 32'd3),           '{32'h0, 1'b1}};
    tab[6]  = '{mk(50, 1, 2, 3, 32'd0),          '{32'h0, 1'b1}};
    tab[7]  = '{mk(24, 1, 1, 0, 32'd32),         '{32'h0, 1'b1}};
    tab[8]  = '{mk(17, 9, 2, 3, 32'hFFFFFFFC),   '{32'hFE312E23, 1'b0}};
    tab[9]  = '{mk(2, 1, 0, 0, 32'hFFF00000),    '{32'h800000EF, 1'b0}};
    tab[10] = '{mk(5, 0, 0, 0, 32'd4094),        '{32'h7E001FE3, 1'b0}};
    tab[11] = '{mk(5, 0, 0, 0, 32'd4096),        '{32'h0, 1'b1}};
    tab[12] = '{mk(39, 3, 4, 5, 32'd1234),       '{32'h00000073, 1'b0}};
    tab[13] = '{mk(40, 3, 4, 5, 32'd77),         '{32'h00100073, 1'b0}};
    tab[14] = '{mk(41, 1, 2, 0, 32'h300),        '{32'h300110F3, 1'b0}};
    tab[15] = '{mk(26, 1, 1, 0, 32'd3),          '{32'h4030D093, 1'b0}};
    tab[16] = '{mk(0, 1, 0, 0, 32'h12345001),    '{32'h0, 1'b1}};
    tab[17] = '{mk(42, 1, 0, 0, 32'h1000),       '{32'h0, 1'b1}};
    tab[18] = '{mk(18, 1, 0, 0, 32'hFFFFF800),   '{32'h80000093, 1'b0}};

    i_op = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0; i_imm = '0;
    do_reset();
    @(negedge clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    chk("rst_cnt_ok", 32'(o_cnt_ok), 32'd0);
    chk("rst_cnt_err", 32'(o_cnt_err), 32'd0);

    // Directed vectors, back-to-back with the consumer always ready.
    for (int i = 0; i < 19; i++) cycle(1'b1, 1'b1, tab[i].r, 1'b1, tab[i].x, acc);
    drain();
    chk("table_cnt_err", 32'(o_cnt_err), 32'd7);

    // Backpressure: three requests offered while the consumer stalls.
    do_reset();
    rq[0] = mk(18, 1, 0, 0, 32'd5);
    rq[1] = mk(0, 5, 0, 0, 32'h12345000);
    rq[2] = mk(28, 3, 1, 2, 32'd0);
    cycle(1'b1, 1'b0, rq[0], 1'b0, none, acc);
    chk("bp_acc0", 32'(acc), 32'd1);
    cycle(1'b1, 1'b0, rq[1], 1'b0, none, acc);
    chk("bp_acc1", 32'(acc), 32'd1);
    cycle(1'b1, 1'b0, rq[2], 1'b0, none, acc);
    chk("bp_stalled", 32'(acc), 32'd0);
    chk("bp_ready_low", 32'(o_ready), 32'd0);
    for (int n = 0; n < 5 && !acc; n++) cycle(1'b1, 1'b1, rq[2], 1'b0, none, acc);
    chk("bp_acc2", 32'(acc), 32'd1);
    drain();
    chk("bp_cnt_ok", 32'(o_cnt_ok), 32'd3);

    // Randomized traffic with random stalls on both sides.
    for (int n = 0; n < 4000; n++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, rand_req(), 1'b0, none, acc);
    drain();
    chk("sat_cnt_ok", 32'(s_cnt_ok4), (exp_ok > 15) ? 32'd15 : 32'(exp_ok));
    chk("sat_cnt_err", 32'(s_cnt_err4), (exp_err > 15) ? 32'd15 : 32'(exp_err));

    // Reset while two results are buffered.
    cycle(1'b1, 1'b0, rq[0], 1'b0, none, acc);
    cycle(1'b1, 1'b0, rq[1], 1'b0, none, acc);
    idle(1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk("mid_rst_inst", o_inst, 32'd0);
    chk("mid_rst_cnt_ok", 32'(o_cnt_ok), 32'd0);
    chk("mid_rst_cnt_err", 32'(o_cnt_err), 32'd0);
    chk("mid_rst_sat_ok", 32'(s_cnt_ok4), 32'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    exp_q.delete();
    exp_ok = 0; exp_err = 0;
    idle(1'b1);
    idle(1'b1);
    chk("post_rst_err", 32'(o_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
